// File: rtl/display_pkg.sv
// Shared types and constants for the dual-digit display multiplexer.
package display_pkg;

    typedef enum logic [1:0] {
        SHOW_A,
        BLANK_A,
        SHOW_B,
        BLANK_B
    } mux_state_t;

    localparam int DEF_REFRESH_CYCLES = 100000;
    localparam int DEF_BLANK_CYCLES   = 2000;

    localparam int SIM_REFRESH = 4;
    localparam int SIM_BLANK   = 1;

endpackage

// File: rtl/display_sync.sv
// Parameterized-width two-flop synchronizer with asynchronous reset.
module display_sync #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/display_mux_ctrl.sv
// Time-multiplexes two switch nibbles onto one seven-segment decoder,
// with per-frame snapshots, blanking between digits and a registered sum.
module display_mux_ctrl
    import display_pkg::*;
#(
    parameter int REFRESH_CYCLES = DEF_REFRESH_CYCLES,
    parameter int BLANK_CYCLES   = DEF_BLANK_CYCLES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] switch1,
    input  logic [3:0] switch2,
    output logic [3:0] digit,
    output logic       anode1_n,
    output logic       anode2_n,
    output logic [4:0] leds,
    output logic       frame_start
);

    localparam int MAXD = (REFRESH_CYCLES > BLANK_CYCLES) ?
                          REFRESH_CYCLES : BLANK_CYCLES;
    localparam int CW   = $clog2(MAXD + 1);
    localparam int BL   = (BLANK_CYCLES == 0) ? 0 : BLANK_CYCLES - 1;
    localparam logic [CW-1:0] SHOW_LAST  = CW'(REFRESH_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BL);
    localparam logic NO_BLANK = (BLANK_CYCLES == 0);

    mux_state_t    state;
    mux_state_t    next_state;
    mux_state_t    succ;
    logic [CW-1:0] count;
    logic          started;
    logic          done;
    logic [7:0]    sw_sync;
    logic [3:0]    snap_a;
    logic [3:0]    snap_b;

    display_sync #(.WIDTH(8)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     ({switch1, switch2}),
        .q     (sw_sync)
    );

    // The first edge out of reset always closes BLANK_B, whatever its length.
    always_comb begin
        done = 1'b0;
        succ = state;
        unique case (state)
            SHOW_A: begin
                done = (count == SHOW_LAST);
                succ = NO_BLANK ? SHOW_B : BLANK_A;
            end
            BLANK_A: begin
                done = NO_BLANK || (count == BLANK_LAST);
                succ = SHOW_B;
            end
            SHOW_B: begin
                done = (count == SHOW_LAST);
                succ = NO_BLANK ? SHOW_A : BLANK_B;
            end
            BLANK_B: begin
                done = !started || NO_BLANK || (count == BLANK_LAST);
                succ = SHOW_A;
            end
        endcase
        next_state = done ? succ : state;
    end

    // Outputs are loaded from next_state so pins switch with the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= BLANK_B;
            count       <= '0;
            started     <= 1'b0;
            snap_a      <= '0;
            snap_b      <= '0;
            digit       <= '0;
            anode1_n    <= 1'b1;
            anode2_n    <= 1'b1;
            leds        <= '0;
            frame_start <= 1'b0;
        end else begin
            started     <= 1'b1;
            frame_start <= 1'b0;
            if (done) begin
                state <= next_state;
                count <= '0;
                unique case (next_state)
                    SHOW_A: begin
                        snap_a      <= sw_sync[7:4];
                        snap_b      <= sw_sync[3:0];
                        leds        <= {1'b0, sw_sync[7:4]} +
                                       {1'b0, sw_sync[3:0]};
                        digit       <= sw_sync[7:4];
                        anode1_n    <= 1'b0;
                        anode2_n    <= 1'b1;
                        frame_start <= 1'b1;
                    end
                    SHOW_B: begin
                        digit    <= snap_b;
                        anode1_n <= 1'b1;
                        anode2_n <= 1'b0;
                    end
                    BLANK_A, BLANK_B: begin
                        anode1_n <= 1'b1;
                        anode2_n <= 1'b1;
                    end
                endcase
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: doc/display_mux_ctrl.md
Name: display_mux_ctrl

Overview:
- Time-multiplexing controller for the lab 2 dual seven-segment display and the 5-LED sum display.
- Synchronizes the two 4-bit switch banks and snapshots both once per frame.
- Alternately steers each nibble to the single shared seven-segment decoder, with blanking (dead time) between digits to prevent ghosting.
- Sits between the switch pins and the existing combinational sum and decoder logic. Also presents the registered 5-bit sum of the snapshot on the LEDs, so digits and LEDs always agree.

Parameters:
- REFRESH_CYCLES, 100000, clk cycles each digit is lit; legal range >= 1.
- BLANK_CYCLES, 2000, clk cycles both anodes are off between digits; 0 removes the blank states.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- switch1  in  4  switch bank for digit A; asynchronous to clk
- switch2  in  4  switch bank for digit B; asynchronous to clk
- digit  out  4  nibble presented to the shared seven-segment decoder
- anode1_n  out  1  digit A enable, active-low
- anode2_n  out  1  digit B enable, active-low
- leds  out  5  snapA + snapB, zero-extended 5-bit sum
- frame_start  out  1  one-cycle pulse on the cycle SHOW_A is entered

Behaviour:
- Reset and clocking: single clock domain. Reset is asynchronous, active-high, and forces every register immediately, including mid-frame.
- Reset values:
  - state = BLANK_B, count = 0
  - digit = 0, anode1_n = 1, anode2_n = 1
  - leds = 0, frame_start = 0
  - synchronizer and snapshot registers = 0
- Input synchronizer: 2-flop synchronizer on {switch1, switch2}. A switch change is visible to the FSM 2 edges later.
- FSM states: SHOW_A -> BLANK_A -> SHOW_B -> BLANK_B -> SHOW_A.
  - SHOW states last REFRESH_CYCLES cycles.
  - BLANK states last BLANK_CYCLES cycles.
  - If BLANK_CYCLES = 0, SHOW_A -> SHOW_B -> SHOW_A directly.
- Counter behaviour:
  - count is reset to 0 on every state transition.
  - A transition occurs on the edge where count == duration-1.
  - Counter width = $clog2(max(REFRESH_CYCLES, BLANK_CYCLES)+1).
- Exit from reset: the first rising edge after reset deasserts is treated as the end of BLANK_B and enters SHOW_A. The first frame therefore displays the reset-zero synchronizer contents.
- Actions on entry to SHOW_A (same edge):
  - snapA and snapB load from the synchronizer outputs.
  - leds <= snapA_new + snapB_new; maximum value 30, no overflow.
  - frame_start = 1 for exactly that cycle.
- Output registration: all outputs are registered and change on the same edge as the state transition, so there is no combinational path from state to pins.
  - SHOW_A: digit = snapA, anode1_n = 0, anode2_n = 1.
  - SHOW_B: digit = snapB, anode1_n = 1, anode2_n = 0.
  - BLANK states: both anodes = 1, digit holds its previous value.
- Invariant: anode1_n and anode2_n are never both 0 on any cycle, including the reset edge.
- Switch changes mid-frame do not affect digit or leds until the next SHOW_A entry; a frame never mixes old and new values.
- Frame period = 2*(REFRESH_CYCLES+BLANK_CYCLES) cycles. Worst-case switch-to-display latency = 2 + frame period cycles.

Decomposition:
- Package display_pkg:
  - typedef enum logic [1:0] mux_state_t {SHOW_A, BLANK_A, SHOW_B, BLANK_B}
  - localparams DEF_REFRESH_CYCLES, DEF_BLANK_CYCLES
  - localparams for simulation values SIM_REFRESH = 4, SIM_BLANK = 1
- One sub-module, display_sync: parameterized-width 2-flop synchronizer with asynchronous reset, instantiated once for 8 bits.
- The seven-segment decoder stays external; this block drives its input only.

Test Plan:
All scenarios use REFRESH_CYCLES = 4 and BLANK_CYCLES = 1.
1. Reset: reset = 1 for 3 cycles with switch1 = 4'hA -> anodes = 11, leds = 0, digit = 0, frame_start = 0 throughout. First edge after release: SHOW_A with digit = 0 and frame_start pulse.
2. Steady frame: hold switch1 = 4'h3, switch2 = 4'h5 for 2 frames -> second frame shows anode pattern 01 x4, 11 x1, 10 x4, 11 x1. digit = 3 then 5, leds = 8, frame_start every 10 cycles.
3. Max sum: switch1 = switch2 = 4'hF -> leds = 5'd30 at the next frame start. Digit A and digit B both show F.
4. Mid-frame change: change switch2 from 4'h5 to 4'h9 during SHOW_A -> SHOW_B of the same frame still shows 5 and leds is unchanged. The next frame shows 9 and leds = 12 (with switch1 = 3).
5. Reset mid-frame: assert reset asynchronously (off-edge) during SHOW_B -> anodes = 11 and leds = 0 immediately, before the next edge. Operation restarts at SHOW_A after release.
6. BLANK_CYCLES = 0 build: no cycle has anodes = 11 after the first frame, and the period is 8 cycles. An assertion checks the anodes-never-both-low invariant across all tests.
